fetch_stage: RTL

//  IF stage plus IF/ID pipeline register for the 5-stage RISC-V core. Holds pcF, drives a req/ack

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns pcF, drives a req/ack instruction-memory port,
// and uses a one-word skid buffer to hold a fetched instruction while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcE,
  input  logic [31:0] pcTargetE,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        fetchBusy
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pcF;
  logic [31:0] redirPc;
  logic        redirPend;
  logic [31:0] skidWord;

  logic [31:0] pcPlus4F;
  logic [31:0] targetAligned;
  logic        dBubble;
  logic        dLoad;
  logic [31:0] dWord;

  function automatic logic [31:0] pcInc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign pcPlus4F      = pcInc(pcF);
  assign targetAligned = {pcTargetE[31:2], 2'b00};
  assign imemReq       = (state == FETCH) && !reset;
  assign imemAddr      = pcF;
  assign fetchBusy     = imemReq && !imemAck;

  // IF/ID update decision; flushD always wins over stallD on the register.
  always_comb begin
    dBubble = 1'b0;
    dLoad   = 1'b0;
    dWord   = imemRdata;
    if (state == FETCH) begin
      if (!imemAck)                dBubble = flushD || !stallD;
      else if (pcSrcE)             dBubble = 1'b1;
      else if (redirPend)          dBubble = flushD || !stallD;
      else if (flushD)             dBubble = 1'b1;
      else if (!(stallD || stallF)) dLoad  = 1'b1;
    end else begin
      if (pcSrcE || flushD) begin
        dBubble = 1'b1;
      end else if (!stallD) begin
        dLoad = 1'b1;
        dWord = skidWord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pcF       <= RESET_PC;
      redirPend <= 1'b0;
      redirPc   <= RESET_PC;
      instrD    <= NOP;
      pcD       <= 32'h0;
      pcPlus4D  <= 32'h0;
      validD    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!imemAck) begin
            // A redirect during a wait is remembered; the outstanding request still completes.
            if (pcSrcE) begin
              redirPend <= 1'b1;
              redirPc   <= targetAligned;
            end
          end else if (pcSrcE) begin
            pcF       <= targetAligned;
            redirPend <= 1'b0;
          end else if (redirPend) begin
            pcF       <= redirPc;
            redirPend <= 1'b0;
          end else if (flushD) begin
            pcF <= pcF;
          end else if (stallD || stallF) begin
            skidWord <= imemRdata;
            state    <= HOLD;
          end else begin
            pcF <= pcPlus4F;
          end
        end
        HOLD: begin
          if (pcSrcE) begin
            pcF   <= targetAligned;
            state <= FETCH;
          end else if (flushD) begin
            state <= FETCH;
          end else if (!stallD) begin
            pcF   <= pcPlus4F;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase

      if (dBubble) begin
        instrD   <= NOP;
        pcD      <= 32'h0;
        pcPlus4D <= 32'h0;
        validD   <= 1'b0;
      end else if (dLoad) begin
        instrD   <= dWord;
        pcD      <= pcF;
        pcPlus4D <= pcPlus4F;
        validD   <= 1'b1;
      end
    end
  end

endmodule
